// File: rtl/regs_wb_queue_if.sv
// Producer/drain/register-file signal bundle for the writeback queue.
// The master side drives producer and drain controls; the slave side is the queue.
interface regs_wb_queue_if #(
    parameter int CW = 3
) ();
    logic          in_valid;
    logic          in_ready;
    logic          in_pair;
    logic [2:0]    in_addr;
    logic [15:0]   in_data;
    logic          drain_en;
    logic          wen;
    logic [2:0]    waddr0;
    logic [7:0]    wdata0;
    logic [2:0]    waddr1;
    logic [7:0]    wdata1;
    logic [7:0]    busy;
    logic          empty;
    logic [CW-1:0] level;

    modport master (
        output in_valid, in_pair, in_addr, in_data, drain_en,
        input  in_ready, wen, waddr0, wdata0, waddr1, wdata1, busy, empty, level
    );

    modport slave (
        input  in_valid, in_pair, in_addr, in_data, drain_en,
        output in_ready, wen, waddr0, wdata0, waddr1, wdata1, busy, empty, level
    );
endinterface

// File: rtl/regs_wb_queue.sv
// In-order writeback queue feeding the 8080 register file dual write port,
// with a per-register pending count so decode can stall on RAW hazards.
module regs_wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    regs_wb_queue_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0] a0;
        logic [7:0] d0;
        logic [2:0] a1;
        logic [7:0] d1;
    } ent_t;

    ent_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic          wen_q, wen_d;
    ent_t          out_q, out_d;
    logic [CW:0]   pend_q [8];
    logic [CW:0]   pend_d [8];
    logic          push, pop;
    ent_t          in_ent;
    logic [7:0]    busy_w;

    always_comb begin
        in_ent = '0;
        if (bus.in_pair) begin
            in_ent.a0 = {bus.in_addr[2:1], 1'b0};
            in_ent.d0 = bus.in_data[15:8];
            in_ent.a1 = {bus.in_addr[2:1], 1'b1};
            in_ent.d1 = bus.in_data[7:0];
        end else begin
            in_ent.a0 = bus.in_addr;
            in_ent.d0 = bus.in_data[7:0];
            in_ent.a1 = bus.in_addr;
            in_ent.d1 = bus.in_data[7:0];
        end
    end

    always_comb begin
        push     = bus.in_valid && (level_q != CW'(DEPTH));
        pop      = bus.drain_en && (level_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        wen_d = pop;
        out_d = pop ? mem_q[rd_ptr_q] : out_q;
    end

    // A pair write touching one register counts once; inc and dec on the same edge cancel.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pend_d[i] = pend_q[i];
            if (push && (in_ent.a0 == 3'(i) || in_ent.a1 == 3'(i)))
                pend_d[i] = pend_d[i] + (CW+1)'(1);
            if (wen_q && (out_q.a0 == 3'(i) || out_q.a1 == 3'(i)))
                pend_d[i] = pend_d[i] - (CW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wen_q    <= 1'b0;
            out_q    <= '0;
            for (int i = 0; i < 8; i++) pend_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wen_q    <= wen_d;
            out_q    <= out_d;
            for (int i = 0; i < 8; i++) pend_q[i] <= pend_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= in_ent;
    end

    always_comb begin
        busy_w = '0;
        for (int i = 0; i < 8; i++) busy_w[i] = (pend_q[i] != '0);
    end

    assign bus.in_ready = (level_q != CW'(DEPTH));
    assign bus.wen      = wen_q;
    assign bus.waddr0   = out_q.a0;
    assign bus.wdata0   = out_q.d0;
    assign bus.waddr1   = out_q.a1;
    assign bus.wdata1   = out_q.d1;
    assign bus.busy     = busy_w;
    assign bus.empty    = (level_q == '0);
    assign bus.level    = level_q;
endmodule

// File: tb/tb_regs_wb_queue.sv
// Directed bench for regs_wb_queue: a cycle model with an expected-entry queue
// is checked against every DUT output after each clock edge.
module tb_regs_wb_queue;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [2:0] a0;
        logic [7:0] d0;
        logic [2:0] a1;
        logic [7:0] d1;
    } ent_t;

    logic clk;
    logic rst_n;
    regs_wb_queue_if #(.CW(CW)) bus ();

    regs_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];
    int   pend [8];
    bit   ew;
    ent_t eo;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t expand(input logic pair, input logic [2:0] a, input logic [15:0] d);
        ent_t e;
        if (pair) begin
            e.a0 = {a[2:1], 1'b0}; e.d0 = d[15:8];
            e.a1 = {a[2:1], 1'b1}; e.d1 = d[7:0];
        end else begin
            e.a0 = a; e.d0 = d[7:0];
            e.a1 = a; e.d1 = d[7:0];
        end
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) pend[i] = 0;
        ew = 1'b0;
        eo = '0;
        last_acc = 1'b0;
    endtask

    task automatic cyc();
        bit   acc, pp;
        ent_t x;
        logic [7:0] eb;
        @(negedge clk);
        chk("in_ready", bus.in_ready, (mq.size() < DEPTH));
        acc = bus.in_valid && (mq.size() < DEPTH);
        pp  = bus.drain_en && (mq.size() != 0);
        x   = expand(bus.in_pair, bus.in_addr, bus.in_data);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (ew) begin
                pend[eo.a0]--;
                if (eo.a1 != eo.a0) pend[eo.a1]--;
            end
            if (acc) begin
                mq.push_back(x);
                pend[x.a0]++;
                if (x.a1 != x.a0) pend[x.a1]++;
            end
            if (pp) begin
                eo = mq.pop_front();
                ew = 1'b1;
            end else begin
                ew = 1'b0;
            end
            last_acc = acc;
        end
        #1;
        eb = '0;
        for (int i = 0; i < 8; i++) eb[i] = (pend[i] != 0);
        chk("wen", bus.wen, ew);
        chk("waddr0", bus.waddr0, eo.a0);
        chk("wdata0", bus.wdata0, eo.d0);
        chk("waddr1", bus.waddr1, eo.a1);
        chk("wdata1", bus.wdata1, eo.d1);
        chk("busy", bus.busy, eb);
        chk("level", bus.level, mq.size());
        chk("empty", bus.empty, (mq.size() == 0));
    endtask

    task automatic drive(input logic v, input logic pair, input logic [2:0] a, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_pair  = pair;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    initial begin
        int k;
        int guard;
        rst_n = 1'b0;
        bus.drain_en = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cyc();
        chk("reset_empty", bus.empty, 1);
        chk("reset_busy", bus.busy, 8'h00);

        // byte write to A
        rst_n = 1'b1;
        bus.drain_en = 1'b1;
        drive(1'b1, 1'b0, 3'd7, 16'h00A5);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        chk("byte_busy_e0", bus.busy, 8'h80);
        cyc();
        chk("byte_wen_e1", bus.wen, 1);
        chk("byte_wdata_e1", {bus.waddr0, bus.wdata0, bus.waddr1, bus.wdata1}, {3'd7, 8'hA5, 3'd7, 8'hA5});
        cyc();
        chk("byte_busy_e2", bus.busy, 8'h00);
        chk("byte_wen_e2", bus.wen, 0);

        // pair write to HL
        drive(1'b1, 1'b1, 3'd4, 16'h1234);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        chk("pair_busy_e0", bus.busy, 8'h30);
        cyc();
        chk("pair_out", {bus.waddr0, bus.wdata0, bus.waddr1, bus.wdata1}, {3'd4, 8'h12, 3'd5, 8'h34});
        chk("pair_busy_e1", bus.busy, 8'h30);
        cyc();
        chk("pair_busy_e2", bus.busy, 8'h00);

        // fill with drain blocked, fifth write stalls
        bus.drain_en = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 3'(k), 16'(32'h40 + k));
            cyc();
            if (last_acc) k++;
        end
        chk("fill_level", bus.level, 4);
        chk("fill_ready", bus.in_ready, 0);
        chk("fill_count", k, 4);
        bus.drain_en = 1'b1;
        guard = 0;
        while (k < 5 && guard < 10) begin
            drive(1'b1, 1'b0, 3'(k), 16'(32'h40 + k));
            cyc();
            if (last_acc) k++;
            guard++;
        end
        chk("fill_fifth_accept", k, 5);
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        guard = 0;
        while ((mq.size() != 0 || ew) && guard < 12) begin
            cyc();
            guard++;
        end
        chk("fill_drained", bus.empty, 1);
        chk("fill_idle_wen", bus.wen, 0);

        // C written twice
        bus.drain_en = 1'b0;
        drive(1'b1, 1'b0, 3'd1, 16'h0011);
        cyc();
        drive(1'b1, 1'b0, 3'd1, 16'h0022);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        chk("dup_busy", bus.busy, 8'h02);
        bus.drain_en = 1'b1;
        cyc();
        chk("dup_first_data", bus.wdata0, 8'h11);
        cyc();
        chk("dup_busy_after_first", bus.busy[1], 1);
        chk("dup_second_data", bus.wdata0, 8'h22);
        cyc();
        chk("dup_busy_clear", bus.busy, 8'h00);
        chk("dup_final", bus.wdata1, 8'h22);

        // steady stream, groups of three writes to the same register
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i[0], 3'(i / 3), 16'(32'hA000 + i * 16'h0101));
            cyc();
            chk("steady_level", bus.level, 1);
            if (i == 2) chk("steady_busy_hold", bus.busy[0], 1);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        guard = 0;
        while ((mq.size() != 0 || ew) && guard < 8) begin
            cyc();
            guard++;
        end
        chk("steady_drained", bus.busy, 8'h00);

        // reset with three queued and one on the write port
        bus.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 3'(2 * i), 16'(32'h5A00 + i));
            cyc();
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        bus.drain_en = 1'b1;
        cyc();
        chk("midrst_level", bus.level, 3);
        chk("midrst_wen", bus.wen, 1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 3'd3, 16'h00EE);
        cyc();
        chk("midrst_wen_clr", bus.wen, 0);
        chk("midrst_busy_clr", bus.busy, 8'h00);
        chk("midrst_empty", bus.empty, 1);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0);
        cyc();
        chk("midrst_no_accept", bus.level, 0);
        chk("midrst_no_write", bus.wen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
